// File: rtl/ber_checker.sv
// Bit-error-rate checker: buffers the reference stream in a bit FIFO, skips the
// receiver lock-in prefix, then scores every received bit against the reference.
module ber_checker #(
  parameter int DEPTH     = 256,
  parameter int SKIP_BITS = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic             stop,
  input  logic             tx_bit,
  input  logic             tx_valid,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow,
  output logic             underflow,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SKIP_W = (SKIP_BITS > 1) ? $clog2(SKIP_BITS) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
  localparam logic [AW:0]       PTR_ONE   = (AW+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SKIP, RUN, HALT} state_t;

  state_t            state, state_n;
  logic [SKIP_W-1:0] skip_cnt, skip_n;
  logic [AW:0]       wr_ptr, wr_n, rd_ptr, rd_n;
  logic [DEPTH-1:0]  mem;
  logic [CNT_W-1:0]  tx_n, rx_n, err_n;
  logic              ovf_n, unf_n, fail_n;
  logic              push, pop, bypass;
  logic              empty, full, head, active;

  // Counters stick at all-ones rather than wrapping back to a misleading small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head   = mem[rd_ptr[AW-1:0]];
  assign active = (state == SKIP) || (state == RUN);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    tx_n    = tx_count;
    rx_n    = rx_count;
    err_n   = err_count;
    ovf_n   = overflow;
    unf_n   = underflow;
    fail_n  = fail;
    push    = 1'b0;
    pop     = 1'b0;
    bypass  = 1'b0;

    if (start) begin
      state_n = (SKIP_BITS == 0) ? RUN : SKIP;
      skip_n  = '0;
      wr_n    = '0;
      rd_n    = '0;
      tx_n    = '0;
      rx_n    = '0;
      err_n   = '0;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
      fail_n  = 1'b0;
    end else begin
      case (state)
        SKIP: begin
          if (tx_valid) begin
            if (skip_cnt == SKIP_LAST) state_n = RUN;
            else                       skip_n  = skip_cnt + SKIP_ONE;
          end
        end
        RUN: begin
          // With nothing buffered, a simultaneous tx bit is itself the reference.
          bypass = rx_valid && tx_valid && empty;
          pop    = rx_valid && !empty;
          if (rx_valid) begin
            rx_n = sat_inc(rx_count);
            if (bypass) begin
              if (rx_bit != tx_bit) err_n = sat_inc(err_count);
            end else if (pop) begin
              if (rx_bit != head) err_n = sat_inc(err_count);
              rd_n = rd_ptr + PTR_ONE;
            end else begin
              unf_n = 1'b1;
            end
          end
          if (tx_valid) begin
            tx_n = sat_inc(tx_count);
            if (!bypass) begin
              if (!full || pop) begin
                push = 1'b1;
                wr_n = wr_ptr + PTR_ONE;
              end else begin
                ovf_n = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase

      // The verdict includes any traffic scored in the stop cycle itself.
      if (stop && active) begin
        state_n = HALT;
        fail_n  = (err_n > threshold) || ovf_n || unf_n;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      fail      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (ce) begin
      state     <= state_n;
      skip_cnt  <= skip_n;
      wr_ptr    <= wr_n;
      rd_ptr    <= rd_n;
      tx_count  <= tx_n;
      rx_count  <= rx_n;
      err_count <= err_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
      fail      <= fail_n;
      busy      <= (state_n == SKIP) || (state_n == RUN);
      done      <= (state_n == HALT);
    end
  end

  // NOTE: the bit store has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (ce && push) mem[wr_ptr[AW-1:0]] <= tx_bit;
  end

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: four parameterisations share one stimulus
// stream and are each compared every cycle against a queue-style reference model.
module tb_ber_checker;

  localparam int N = 4;
  localparam int P_IDLE = 0, P_SKIP = 1, P_RUN = 2, P_HALT = 3;

  logic        clk, reset, ce, start, stop;
  logic        tx_bit, tx_valid, rx_bit, rx_valid;
  logic [31:0] threshold;

  wire [31:0] w_tx [N];
  wire [31:0] w_rx [N];
  wire [31:0] w_err [N];
  wire        w_ovf [N];
  wire        w_unf [N];
  wire        w_busy [N];
  wire        w_done [N];
  wire        w_fail [N];
  wire [3:0]  tx3, rx3, err3;

  assign w_tx[3]  = {28'd0, tx3};
  assign w_rx[3]  = {28'd0, rx3};
  assign w_err[3] = {28'd0, err3};

  ber_checker #(.DEPTH(256), .SKIP_BITS(0), .CNT_W(32)) u_plain (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .stop(stop),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .threshold(threshold), .tx_count(w_tx[0]), .rx_count(w_rx[0]), .err_count(w_err[0]),
    .overflow(w_ovf[0]), .underflow(w_unf[0]), .busy(w_busy[0]), .done(w_done[0]), .fail(w_fail[0]));

  ber_checker #(.DEPTH(256), .SKIP_BITS(16), .CNT_W(32)) u_skip (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .stop(stop),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .threshold(threshold), .tx_count(w_tx[1]), .rx_count(w_rx[1]), .err_count(w_err[1]),
    .overflow(w_ovf[1]), .underflow(w_unf[1]), .busy(w_busy[1]), .done(w_done[1]), .fail(w_fail[1]));

  ber_checker #(.DEPTH(4), .SKIP_BITS(0), .CNT_W(32)) u_small (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .stop(stop),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .threshold(threshold), .tx_count(w_tx[2]), .rx_count(w_rx[2]), .err_count(w_err[2]),
    .overflow(w_ovf[2]), .underflow(w_unf[2]), .busy(w_busy[2]), .done(w_done[2]), .fail(w_fail[2]));

  ber_checker #(.DEPTH(8), .SKIP_BITS(0), .CNT_W(4)) u_narrow (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .stop(stop),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .threshold(threshold[3:0]), .tx_count(tx3), .rx_count(rx3), .err_count(err3),
    .overflow(w_ovf[3]), .underflow(w_unf[3]), .busy(w_busy[3]), .done(w_done[3]), .fail(w_fail[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO held as a ring with an occupancy count per instance.
  int     cfg_depth [N] = '{256, 256, 4, 8};
  int     cfg_skip  [N] = '{0, 16, 0, 0};
  longint cmax      [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int     ph [N], skp [N], fcnt [N], fhead [N];
  longint mtx [N], mrx [N], merr [N];
  bit     movf [N], munf [N], mfail [N];
  bit     fdata [N][256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit st, sp, tb, tv, rb, rv;
    int etx, erx, eerr;
    bit eovf, eunf, ebusy, edone, efail;
  } vec_t;
  vec_t tbl [14];
  bit   bits [256];

  function automatic longint sat(input longint v, input int i);
    return (v < cmax[i]) ? v + 1 : v;
  endfunction

  task automatic mreset(input int i);
    ph[i] = P_IDLE; skp[i] = 0; fcnt[i] = 0; fhead[i] = 0;
    mtx[i] = 0; mrx[i] = 0; merr[i] = 0;
    movf[i] = 1'b0; munf[i] = 1'b0; mfail[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    bit     was_active;
    bit     ref_bit;
    longint thr;
    was_active = (ph[i] == P_SKIP) || (ph[i] == P_RUN);
    thr = longint'(threshold) & cmax[i];
    if (start) begin
      mreset(i);
      ph[i] = (cfg_skip[i] == 0) ? P_RUN : P_SKIP;
      return;
    end
    if (ph[i] == P_SKIP) begin
      if (tx_valid) begin
        skp[i]++;
        if (skp[i] == cfg_skip[i]) ph[i] = P_RUN;
      end
    end else if (ph[i] == P_RUN) begin
      if (tx_valid && rx_valid && fcnt[i] == 0) begin
        mtx[i] = sat(mtx[i], i);
        mrx[i] = sat(mrx[i], i);
        if (tx_bit != rx_bit) merr[i] = sat(merr[i], i);
      end else begin
        if (rx_valid) begin
          mrx[i] = sat(mrx[i], i);
          if (fcnt[i] > 0) begin
            ref_bit  = fdata[i][fhead[i]];
            fhead[i] = (fhead[i] + 1) % cfg_depth[i];
            fcnt[i]--;
            if (ref_bit != rx_bit) merr[i] = sat(merr[i], i);
          end else begin
            munf[i] = 1'b1;
          end
        end
        if (tx_valid) begin
          mtx[i] = sat(mtx[i], i);
          if (fcnt[i] < cfg_depth[i]) begin
            fdata[i][(fhead[i] + fcnt[i]) % cfg_depth[i]] = tx_bit;
            fcnt[i]++;
          end else begin
            movf[i] = 1'b1;
          end
        end
      end
    end
    if (stop && was_active) begin
      ph[i]    = P_HALT;
      mfail[i] = (merr[i] > thr) || movf[i] || munf[i];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    bit eb, ed;
    eb = (ph[i] == P_SKIP) || (ph[i] == P_RUN);
    ed = (ph[i] == P_HALT);
    checks++;
    if (w_tx[i] !== 32'(mtx[i]) || w_rx[i] !== 32'(mrx[i]) || w_err[i] !== 32'(merr[i]) ||
        w_ovf[i] !== movf[i] || w_unf[i] !== munf[i] || w_busy[i] !== eb ||
        w_done[i] !== ed || w_fail[i] !== mfail[i]) begin
      errors++;
      $display("FAIL model_inst%0d t=%0t: got tx=%0d rx=%0d err=%0d ovf=%b unf=%b busy=%b done=%b fail=%b expected tx=%0d rx=%0d err=%0d ovf=%b unf=%b busy=%b done=%b fail=%b",
               i, $time, w_tx[i], w_rx[i], w_err[i], w_ovf[i], w_unf[i], w_busy[i], w_done[i], w_fail[i],
               mtx[i], mrx[i], merr[i], movf[i], munf[i], eb, ed, mfail[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (ce) for (int i = 0; i < N; i++) model_step(i);
    #1;
    for (int i = 0; i < N; i++) check_inst(i);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit tb, input bit tv, input bit rb, input bit rv);
    start = st; stop = sp; tx_bit = tb; tx_valid = tv; rx_bit = rb; rx_valid = rv;
    tick();
    start = 1'b0; stop = 1'b0; tx_valid = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    // Directed vectors for the plain instance, applied straight out of reset.
    //            st sp tb tv rb rv  tx rx err ovf unf busy done fail
    tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 0,  1, 0, 0,  0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0, 0,  2, 0, 0,  0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 1,  2, 1, 0,  0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 1,  2, 2, 1,  0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1,  2, 3, 1,  0, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 1,  3, 4, 1,  0, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 1,  4, 5, 2,  0, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 0, 0,  5, 5, 2,  0, 1, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 1, 0, 1,  5, 5, 2,  0, 1, 0, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 0,  5, 5, 2,  0, 1, 0, 1, 1};

    reset = 1'b1; ce = 1'b1; start = 1'b0; stop = 1'b0;
    tx_bit = 1'b0; tx_valid = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0;
    threshold = 32'd1;
    for (int i = 0; i < N; i++) mreset(i);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) check_inst(i);
    reset = 1'b0;

    for (int r = 0; r < 14; r++) begin
      cyc(tbl[r].st, tbl[r].sp, tbl[r].tb, tbl[r].tv, tbl[r].rb, tbl[r].rv);
      check($sformatf("row%0d_tx", r),   w_tx[0],   tbl[r].etx);
      check($sformatf("row%0d_rx", r),   w_rx[0],   tbl[r].erx);
      check($sformatf("row%0d_err", r),  w_err[0],  tbl[r].eerr);
      check($sformatf("row%0d_ovf", r),  w_ovf[0],  tbl[r].eovf);
      check($sformatf("row%0d_unf", r),  w_unf[0],  tbl[r].eunf);
      check($sformatf("row%0d_busy", r), w_busy[0], tbl[r].ebusy);
      check($sformatf("row%0d_done", r), w_done[0], tbl[r].edone);
      check($sformatf("row%0d_fail", r), w_fail[0], tbl[r].efail);
    end

    // Clean loopback: 200 bits, rx lagging by 40 cycles.
    for (int k = 0; k < 256; k++) bits[k] = 1'($urandom_range(0, 1));
    threshold = 32'd0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 240; c++)
      cyc(0, 0, (c < 200) ? bits[c] : 1'b0, c < 200, (c >= 40) ? bits[c - 40] : 1'b0, c >= 40);
    cyc(0, 1, 0, 0, 0, 0);
    check("loop_tx", w_tx[0], 200);
    check("loop_rx", w_rx[0], 200);
    check("loop_err", w_err[0], 0);
    check("loop_fail", w_fail[0], 0);
    check("loop_done", w_done[0], 1);

    // Skip phase of 16 bits, two flipped rx bits, judged at two thresholds.
    for (int thr = 1; thr <= 2; thr++) begin
      threshold = 32'(thr);
      cyc(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 221; c++) begin
        int j;
        bit rb;
        j  = c - 21;
        rb = (j >= 0 && j < 200) ? (bits[16 + j] ^ (j == 3 || j == 150)) : 1'b0;
        cyc(0, 0, (c < 216) ? bits[c] : 1'b0, c < 216, rb, j >= 0 && j < 200);
      end
      cyc(0, 1, 0, 0, 0, 0);
      check($sformatf("skip_thr%0d_tx", thr), w_tx[1], 200);
      check($sformatf("skip_thr%0d_err", thr), w_err[1], 2);
      check($sformatf("skip_thr%0d_fail", thr), w_fail[1], (thr == 1) ? 1 : 0);
    end

    // Four-deep FIFO overflow: six tx, then rx of the four retained bits.
    threshold = 32'd10;
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, bits[k], 1, 0, 0);
    check("ovf_tx", w_tx[2], 6);
    check("ovf_flag", w_ovf[2], 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, bits[k], 1);
    check("ovf_err", w_err[2], 0);
    check("ovf_unf", w_unf[2], 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("ovf_fail", w_fail[2], 1);

    // Bypass on an empty FIFO, then an unmatched rx.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, bits[k], 1, bits[k] ^ (k == 2 || k == 7), 1);
    check("byp_err", w_err[0], 2);
    check("byp_unf", w_unf[0], 0);
    check("byp_rx", w_rx[0], 10);
    cyc(0, 0, 0, 0, 1, 1);
    check("byp_unf_after", w_unf[0], 1);

    // Restart mid-run, traffic in the start cycle ignored; then async reset.
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("restart_pre_err", w_err[0], 5);
    cyc(1, 0, 1, 1, 0, 1);
    check("restart_tx", w_tx[0], 0);
    check("restart_rx", w_rx[0], 0);
    check("restart_err", w_err[0], 0);
    check("restart_unf", w_unf[0], 0);
    check("restart_busy", w_busy[0], 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, bits[k], 1, 0, 0);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) mreset(i);
    for (int i = 0; i < N; i++) check_inst(i);
    check("areset_tx", w_tx[0], 0);
    check("areset_busy", w_busy[0], 0);
    reset = 1'b0;

    // Saturation on the 4-bit instance.
    threshold = 32'd0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 1, 0, 1);
    check("sat_err", w_err[3], 15);
    check("sat_tx", w_tx[3], 15);
    cyc(0, 1, 0, 0, 0, 0);
    check("sat_fail", w_fail[3], 1);

    // A start pulse during ce=0 is lost.
    ce = 1'b0;
    cyc(1, 0, 1, 1, 1, 1);
    ce = 1'b1;
    check("ce_done", w_done[3], 1);
    check("ce_busy", w_busy[3], 0);

    // Randomised traffic across all four instances against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) threshold = 32'($urandom_range(0, 20));
      ce = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 249) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
          1'($urandom_range(0, 1)), $urandom_range(0, 9) < 5);
    end
    ce = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
